// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the Wishbone bus arbiter: state encoding, bus widths, index sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_bus_arbiter_pkg;

    localparam int ADR_W = 16;
    localparam int DAT_W = 16;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_HAND = 2'd1,
        ST_DMA  = 2'd2
    } arb_state_e;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping modulo NDMA.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module wb_rr_pick
    import wb_bus_arbiter_pkg::*;
#(
    parameter int NDMA = 2,
    parameter int IW   = clog2(NDMA)
) (
    input  logic [NDMA-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Scan NDMA candidates starting at the pointer; the first hit wins.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NDMA; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(NDMA)) begin
                sum = sum - (IW+1)'(NDMA);
            end
            cand = sum[IW-1:0];
            if (!vld_o && req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Shares the Wishbone bus between the CPU and NDMA DMA masters, with a one-clock dead handover.
// Latency: bus mux and ack steering are combinational; ownership changes take effect one clock after the decision.
// Backpressure: CPU stalls via cpu_gnt_o=0; DMA masters wait for dma_gnt_o; stuck DMA strobes get a fake ack + err.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int NDMA     = 2,
    parameter int MAX_HOLD = 64,
    parameter int TMO      = 255
) (
    input  logic                    clk_p,
    input  logic                    rst_n,
    input  logic [ADR_W-1:0]        cpu_adr_i,
    input  logic [DAT_W-1:0]        cpu_dat_i,
    input  logic                    cpu_cyc_i,
    input  logic                    cpu_stb_i,
    input  logic                    cpu_we_i,
    input  logic [SEL_W-1:0]        cpu_sel_i,
    output logic                    cpu_gnt_o,
    output logic                    cpu_ack_o,
    input  logic [NDMA-1:0]         dma_req_i,
    output logic [NDMA-1:0]         dma_gnt_o,
    input  logic [NDMA*ADR_W-1:0]   dma_adr_i,
    input  logic [NDMA*DAT_W-1:0]   dma_dat_i,
    input  logic [NDMA-1:0]         dma_cyc_i,
    input  logic [NDMA-1:0]         dma_stb_i,
    input  logic [NDMA-1:0]         dma_we_i,
    input  logic [NDMA*SEL_W-1:0]   dma_sel_i,
    output logic [NDMA-1:0]         dma_ack_o,
    output logic [NDMA-1:0]         dma_err_o,
    output logic [ADR_W-1:0]        bus_adr_o,
    output logic [DAT_W-1:0]        bus_dat_o,
    output logic                    bus_cyc_o,
    output logic                    bus_stb_o,
    output logic                    bus_we_o,
    output logic [SEL_W-1:0]        bus_sel_o,
    input  logic                    bus_ack_i
);

    localparam int IW = clog2(NDMA);
    localparam int HW = clog2(MAX_HOLD);
    localparam int TW = clog2(TMO);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDMA - 1);

    // src_dma_q/src_idx_q select the mux source; cleared back to CPU when a DMA tenure ends.
    arb_state_e      state_q, state_d;
    logic            src_dma_q, src_dma_d;
    logic [IW-1:0]   src_idx_q, src_idx_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_vld;

    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat;
    logic             own_cyc;
    logic             own_stb;
    logic             own_we;
    logic [SEL_W-1:0] own_sel;
    logic [NDMA-1:0]  own_mask;

    logic             in_dma;
    logic             others_req;
    logic             tmo_hit;

    wb_rr_pick #(
        .NDMA (NDMA),
        .IW   (IW)
    ) u_pick (
        .req_i (dma_req_i),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // Source mux: the registered owner drives the shared bus signals.
    always_comb begin
        own_adr = cpu_adr_i;
        own_dat = cpu_dat_i;
        own_cyc = cpu_cyc_i;
        own_stb = cpu_stb_i;
        own_we  = cpu_we_i;
        own_sel = cpu_sel_i;
        if (src_dma_q) begin
            own_adr = dma_adr_i[src_idx_q*ADR_W +: ADR_W];
            own_dat = dma_dat_i[src_idx_q*DAT_W +: DAT_W];
            own_cyc = dma_cyc_i[src_idx_q];
            own_stb = dma_stb_i[src_idx_q];
            own_we  = dma_we_i[src_idx_q];
            own_sel = dma_sel_i[src_idx_q*SEL_W +: SEL_W];
        end
    end

    // One-hot of the current DMA source, used for grant, ack steering and "other requesters".
    always_comb begin
        own_mask            = '0;
        own_mask[src_idx_q] = 1'b1;
    end

    assign in_dma     = (state_q == ST_DMA);
    assign others_req = |(dma_req_i & ~own_mask);
    assign tmo_hit    = in_dma & own_stb & (tmo_cnt_q == TMO_LAST);

    // Shared bus outputs: zero while in reset, cyc/stb held low during the dead handover clock.
    always_comb begin
        bus_adr_o = '0;
        bus_dat_o = '0;
        bus_cyc_o = 1'b0;
        bus_stb_o = 1'b0;
        bus_we_o  = 1'b0;
        bus_sel_o = '0;
        if (rst_n) begin
            bus_adr_o = own_adr;
            bus_dat_o = own_dat;
            bus_cyc_o = own_cyc & (state_q != ST_HAND);
            bus_stb_o = own_stb & (state_q != ST_HAND);
            bus_we_o  = own_we;
            bus_sel_o = own_sel;
        end
    end

    assign cpu_gnt_o = (state_q == ST_CPU);
    assign cpu_ack_o = bus_ack_i & (state_q == ST_CPU);

    // Grant and ack/err steering to the owning DMA master only; an ack with the timeout suppresses err.
    always_comb begin
        dma_gnt_o = '0;
        dma_ack_o = '0;
        dma_err_o = '0;
        if (in_dma) begin
            dma_gnt_o = own_mask;
            dma_ack_o = (bus_ack_i | tmo_hit) ? own_mask : '0;
            dma_err_o = (tmo_hit & ~bus_ack_i) ? own_mask : '0;
        end
    end

    // Ownership FSM: CPU -> HAND -> DMA(k) -> HAND -> CPU, never preempting an active cycle.
    always_comb begin
        state_d    = state_q;
        src_dma_d  = src_dma_q;
        src_idx_d  = src_idx_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = '0;
        case (state_q)
            ST_CPU: begin
                if (pick_vld && !cpu_cyc_i) begin
                    state_d   = ST_HAND;
                    src_dma_d = 1'b1;
                    src_idx_d = pick_idx;
                end
            end
            ST_HAND: begin
                if (src_dma_q && dma_req_i[src_idx_q]) begin
                    state_d = ST_DMA;
                end else begin
                    state_d   = ST_CPU;
                    src_dma_d = 1'b0;
                end
            end
            ST_DMA: begin
                hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HW'(1);
                if (!own_cyc &&
                    (!dma_req_i[src_idx_q] ||
                     ((hold_cnt_q == HOLD_LAST) && (others_req || cpu_cyc_i)))) begin
                    state_d    = ST_HAND;
                    src_dma_d  = 1'b0;
                    rr_ptr_d   = (src_idx_q == IDX_LAST) ? '0 : src_idx_q + IW'(1);
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CPU;
                src_dma_d = 1'b0;
            end
        endcase
    end

    // Timeout counter: consecutive unacknowledged DMA strobe clocks, restarting after each hit.
    always_comb begin
        tmo_cnt_d = '0;
        if (in_dma && own_stb && !bus_ack_i && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    // State registers with asynchronous reset back to CPU ownership.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CPU;
            src_dma_q  <= 1'b0;
            src_idx_q  <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_dma_q  <= src_dma_d;
            src_idx_q  <= src_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the processor-board Wishbone bus between the VM2 CPU master and up to NDMA DMA masters (disk/floppy controllers).
- Produces the CPU grant (1 = CPU owns the bus; 0 = CPU stalls waiting for ack).
- Multiplexes the owning master onto the shared bus and routes ack back to that master only.
- Enforces handover only at cycle boundaries, round-robin among DMA masters, a hold limit, and a DMA bus timeout.

Parameters:
NDMA, 2, number of DMA requesters (1..4)
MAX_HOLD, 64, max clocks a DMA master keeps ownership while other masters wait
TMO, 255, clocks a granted DMA strobe may wait for bus_ack_i before timeout

Ports:
clk_p  in  1  positive system clock
rst_n  in  1  asynchronous active-low reset
cpu_adr_i  in  16  CPU address
cpu_dat_i  in  16  CPU write data
cpu_cyc_i / cpu_stb_i / cpu_we_i  in  1 each  CPU Wishbone controls
cpu_sel_i  in  2  CPU byte select
cpu_gnt_o  out  1  CPU bus grant
cpu_ack_o  out  1  ack routed to the CPU
dma_req_i  in  NDMA  DMA bus requests
dma_gnt_o  out  NDMA  one-hot DMA grant
dma_adr_i / dma_dat_i  in  16*NDMA each  packed DMA address and write data
dma_cyc_i / dma_stb_i / dma_we_i  in  NDMA each  DMA controls
dma_sel_i  in  2*NDMA  DMA byte selects
dma_ack_o  out  NDMA  ack routed to each DMA master
dma_err_o  out  NDMA  timeout error pulse per DMA master
bus_adr_o / bus_dat_o  out  16 each  shared bus address and write data
bus_cyc_o / bus_stb_o / bus_we_o  out  1 each  shared bus controls
bus_sel_o  out  2  shared bus byte select
bus_ack_i  in  1  global ack from memory and I/O page

Behaviour:
- Reset, asynchronous on rst_n low:
  - state CPU, cpu_gnt_o=1, dma_gnt_o=0, rr_ptr=0.
  - hold_cnt=0, tmo_cnt=0, dma_err_o=0.
  - All bus_* outputs 0.
- Owner register: selects the mux source.
  - bus_* = owner's signals, except bus_cyc_o/bus_stb_o, which are forced 0 in state HAND.
  - Ack steering is combinational: cpu_ack_o = bus_ack_i & owner==CPU; dma_ack_o[k] = (bus_ack_i | tmo_hit) & owner==k.
- State CPU:
  - If |dma_req_i and cpu_cyc_i==0, latch the winner and go to HAND; cpu_gnt_o drops on that edge.
  - Winner = first requester at or after rr_ptr, wrapping modulo NDMA.
  - Never preempt while cpu_cyc_i==1.
- State HAND:
  - One dead clock with no cyc on the bus.
  - Then DMA(winner): dma_gnt_o[winner]=1.
  - If the winner dropped its request during HAND, return to CPU instead.
- State DMA(k):
  - hold_cnt increments each clock.
  - Release when dma_cyc_i[k]==0 and either (a) dma_req_i[k]==0, or (b) hold_cnt>=MAX_HOLD-1 and another request or cpu_cyc_i is pending.
  - On release: rr_ptr=k+1 mod NDMA, go to HAND then CPU. The CPU always gets a slot between two DMA tenures.
  - If cpu_cyc_i is low and other DMA requests are pending, the CPU state hands over again after its one clock.
- Timeout, DMA owner only:
  - tmo_cnt counts while bus_stb_o & ~bus_ack_i; clears on ack or when stb is low.
  - When tmo_cnt==TMO-1, tmo_hit pulses for 1 clock: fake ack to dma_ack_o[k] and dma_err_o[k]=1 for 1 clock.
  - No timeout is applied for the CPU; the core traps by itself.
- Simultaneous events:
  - A request arriving in the same clock as cpu_cyc_i rising is deferred; the CPU keeps the bus.
  - dma_req_i dropping mid-cycle does not release until dma_cyc_i falls.
  - Ack in the same clock as tmo_hit produces a single ack, and no err.
- Non-granted DMA acks are 0. When cpu_gnt_o=0, cpu_ack_o is 0 and the CPU stalls.
- rst_n low mid-transfer: everything returns to reset values immediately; the in-flight cycle is abandoned.

Decomposition:
- Shared package holds:
  - state encoding (ST_CPU, ST_HAND, ST_DMA).
  - DMA index width function clog2(NDMA).
  - bus width constants ADR_W=16, DAT_W=16, SEL_W=2.
- One sub-module: wb_rr_pick. It is combinational: from request vector and rr_ptr it produces the winner index and a valid flag.

Test Plan:
- Reset: rst_n low with all requests high → cpu_gnt_o=1, dma_gnt_o=00, bus_cyc_o=0; after release with no requests, CPU transfers pass with adr 0o157776 unchanged.
- dma_req_i=01 while CPU cycle is active → grant is deferred until cpu_cyc_i falls; then one HAND clock, dma_gnt_o=01, cpu_gnt_o=0.
- dma_req_i=11 held continuously → sequence DMA0, CPU slot, DMA1, CPU slot, DMA0 (round-robin); each tenure ends at MAX_HOLD=64 on a cyc boundary.
- DMA1 strobes with no bus_ack_i → exactly at clock TMO=255, dma_ack_o[1] and dma_err_o[1] pulse once; the bus stays with DMA1.
- bus_ack_i in the same clock as timeout expiry → single ack, dma_err_o=0.
- rst_n asserted mid-DMA → outputs reset asynchronously; cpu_gnt_o=1 before the next clk_p edge.
